i2c_slave_ctrl: RTL and testbench
=================================

I2C_SLAVE_CTRL -- requirements
Module: i2c_slave_ctrl

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h2A, the 7-bit address this slave answers to.
REQ-002 SHALL have ports:
- clk  in  1  system clock, all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- scl_rise  in  1  one-cycle pulse, SCL rising edge found (from scl_edge).
- scl_fall  in  1  one-cycle pulse, SCL falling edge found (from scl_edge).
- start_found  in  1  one-cycle pulse, START or repeated START detected.
- stop_found  in  1  one-cycle pulse, STOP detected.
- sda_in  in  1  synchronized SDA level.
- rx_read  in  1  consumer pops the held byte.
- sda_drive  out  1  1 = pull SDA low (ACK).
- rx_data  out  8  last received data byte.
- rx_full  out  1  held byte not yet consumed.
- overrun  out  1  sticky; byte lost because rx_full was set.
- addr_match  out  1  current transaction addressed to this slave.
- busy  out  1  state != IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
REQ-004 IDLE -> ADDR on start_found; bit counter cleared to 0.
REQ-005 ADDR/DATA SHALL sample sda_in MSB-first into an 8-bit shift register on each scl_rise and increment the bit counter.
REQ-006 On the scl_fall following the 8th scl_rise: in ADDR, go to ADDR_ACK if shift[7:1]==SLAVE_ADDR and shift[0]==0, else go to IGNORE.
REQ-007 ADDR_ACK SHALL set addr_match=1, assert sda_drive from entry until the next scl_fall, then go to DATA with the counter cleared.
REQ-008 On the scl_fall after the 8th data bit: if rx_full==0, load rx_data, set rx_full, and go to DATA_ACK with sda_drive=1; if rx_full==1, set overrun, leave rx_data unchanged, and go to DATA_ACK with sda_drive=0 (NACK).
REQ-009 DATA_ACK SHALL hold sda_drive until the next scl_fall, then go to DATA (ACK) or IGNORE (NACK).
REQ-010 IGNORE SHALL keep sda_drive=0 and leave only on start_found or stop_found.
REQ-011 stop_found in any state -> IDLE, sda_drive=0, addr_match=0; rx_data, rx_full and overrun are kept.
REQ-012 start_found in any non-IDLE state -> ADDR (repeated start), counter cleared, addr_match=0, sda_drive=0.
REQ-013 If start_found and stop_found occur in the same cycle, stop_found SHALL take priority.
REQ-014 rx_read SHALL clear rx_full in the same cycle it is seen. If rx_read and a byte load occur in the same cycle, the load SHALL win and rx_full stays 1 with no overrun.
REQ-015 scl_rise and scl_fall in the same cycle SHALL be ignored (no sample, no advance).
REQ-016 overrun SHALL clear only on rst.

Reset
REQ-017 On rst: state=IDLE, counter=0, shift=0, rx_data=8'h00, rx_full=0, overrun=0, addr_match=0, sda_drive=0, busy=0.
REQ-018 rst SHALL override all inputs in the same cycle, including mid-byte and mid-ACK; sda_drive SHALL be 0 on the next cycle.

Configuration
REQ-019 Macro I2C_SLAVE_GENCALL_EN defined: address byte 8'h00 (general call, write) SHALL also match per REQ-006. Undefined: 8'h00 SHALL go to IGNORE.

Structure
REQ-020 Package i2c_pkg SHALL hold the state enum typedef, ADDR_W=7, BYTE_W=8 and GENCALL_ADDR=7'h00.
REQ-021 The bit counter SHALL be a sub-module flex_counter (4-bit, clear, count_enable, rollover_val=8, rollover_flag).

Verification
REQ-022 Bench SHALL cover these directed scenarios:
- START, address byte 8'h54, then data 8'hA5 -> ACK (sda_drive=1) on both 9th clocks; rx_data=8'hA5, rx_full=1.
- START, address byte 8'h56 (wrong address) -> no ACK, state IGNORE; after STOP, busy=0.
- Two bytes 8'h11 and 8'h22 with no rx_read -> second byte NACKed, overrun=1, rx_data=8'h11.
- START, 4 address bits, then repeated START, then 8'h54 -> ACK; counter restarted.
- rst asserted during ADDR_ACK -> sda_drive=0 and all outputs at reset values next cycle.
- Address byte 8'h00 -> ACK with I2C_SLAVE_GENCALL_EN defined, IGNORE without it.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave receive controller.
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int BYTE_W = 8;
  localparam int CNT_W  = 4;

  localparam logic [ADDR_W-1:0] GENCALL_ADDR = 7'h00;
  localparam logic [CNT_W-1:0]  BITS_PER_BYTE = 4'd8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    DATA     = 3'd3,
    DATA_ACK = 3'd4,
    IGNORE   = 3'd5
  } state_e;

  // Address byte selects this slave for a write: own address, or the
  // general-call address when that feature is enabled. R/W bit must be 0.
  function automatic logic addr_hit(input logic [BYTE_W-1:0] addr_byte,
                                    input logic [ADDR_W-1:0] own_addr,
                                    input logic              gencall_en);
    logic hit;
    hit = 1'b0;
    if (addr_byte[0] == 1'b0) begin
      if (addr_byte[BYTE_W-1:1] == own_addr) begin
        hit = 1'b1;
      end else if (gencall_en && (addr_byte[BYTE_W-1:1] == GENCALL_ADDR)) begin
        hit = 1'b1;
      end else begin
        hit = 1'b0;
      end
    end else begin
      hit = 1'b0;
    end
    return hit;
  endfunction

endpackage

// File: rtl/i2c_slave_ctrl_flex_counter.sv
// Bit counter for the I2C slave: clears, counts on enable, wraps to 1 after
// reaching rollover_val, and flags (registered) when the count equals rollover_val.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    flag_q, flag_d;

  // Next count value and whether it lands on the rollover value.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (count_q == rollover_val) begin
        count_d = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};
      end else begin
        count_d = count_q + {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};
      end
    end else begin
      count_d = count_q;
    end
    flag_d = (count_d == rollover_val);
  end

  // Count and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  assign rollover_flag = flag_q;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C slave receive controller (write-only target). Decodes the address
// byte, ACKs matching transactions, captures data bytes into a one-entry
// holding register and NACKs on overrun.
// Optional feature: define I2C_SLAVE_GENCALL_EN to also accept the general
// call address (byte 8'h00).
module i2c_slave_ctrl
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h2A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_rise,
  input  logic       scl_fall,
  input  logic       start_found,
  input  logic       stop_found,
  input  logic       sda_in,
  input  logic       rx_read,
  output logic       sda_drive,
  output logic [7:0] rx_data,
  output logic       rx_full,
  output logic       overrun,
  output logic       addr_match,
  output logic       busy
);

`ifdef I2C_SLAVE_GENCALL_EN
  localparam logic GENCALL_EN = 1'b1;
`else
  localparam logic GENCALL_EN = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   shift_q, shift_d;
  logic [BYTE_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_full_q, rx_full_d;
  logic                overrun_q, overrun_d;
  logic                ack_q, ack_d;
  logic                sda_drive_q, sda_drive_d;
  logic                addr_match_q, addr_match_d;
  logic                busy_q, busy_d;

  logic                rise_v_s, fall_v_s;
  logic                cnt_clear_s, cnt_en_s, byte_done_s;
  logic                holding_s;

  // Simultaneous rise and fall is treated as noise and ignored.
  assign rise_v_s  = scl_rise & ~scl_fall;
  assign fall_v_s  = scl_fall & ~scl_rise;
  // A pop in the same cycle frees the holding register for a new load.
  assign holding_s = rx_full_q & ~rx_read;

  flex_counter #(
    .NUM_CNT_BITS (CNT_W)
  ) u_bit_cnt (
    .clk           (clk),
    .rst           (rst),
    .clear         (cnt_clear_s),
    .count_enable  (cnt_en_s),
    .rollover_val  (BITS_PER_BYTE),
    .rollover_flag (byte_done_s)
  );

  // State and datapath registers; reset overrides every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= 8'h00;
      rx_data_q    <= 8'h00;
      rx_full_q    <= 1'b0;
      overrun_q    <= 1'b0;
      ack_q        <= 1'b0;
      sda_drive_q  <= 1'b0;
      addr_match_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_full_q    <= rx_full_d;
      overrun_q    <= overrun_d;
      ack_q        <= ack_d;
      sda_drive_q  <= sda_drive_d;
      addr_match_q <= addr_match_d;
      busy_q       <= busy_d;
    end
  end

  // Next state, bit sampling and byte hand-off; STOP beats START.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_full_d   = rx_full_q & ~rx_read;
    overrun_d   = overrun_q;
    ack_d       = ack_q;
    cnt_clear_s = 1'b0;
    cnt_en_s    = 1'b0;
    if (stop_found) begin
      state_d     = IDLE;
      cnt_clear_s = 1'b1;
    end else if (start_found) begin
      state_d     = ADDR;
      cnt_clear_s = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        ADDR: begin
          if (rise_v_s) begin
            shift_d  = {shift_q[BYTE_W-2:0], sda_in};
            cnt_en_s = 1'b1;
          end else if (fall_v_s && byte_done_s) begin
            if (addr_hit(shift_q, SLAVE_ADDR, GENCALL_EN)) begin
              state_d = ADDR_ACK;
            end else begin
              state_d = IGNORE;
            end
          end else begin
            state_d = ADDR;
          end
        end
        ADDR_ACK: begin
          if (fall_v_s) begin
            state_d     = DATA;
            cnt_clear_s = 1'b1;
          end else begin
            state_d = ADDR_ACK;
          end
        end
        DATA: begin
          if (rise_v_s) begin
            shift_d  = {shift_q[BYTE_W-2:0], sda_in};
            cnt_en_s = 1'b1;
          end else if (fall_v_s && byte_done_s) begin
            state_d = DATA_ACK;
            if (!holding_s) begin
              rx_data_d = shift_q;
              rx_full_d = 1'b1;
              ack_d     = 1'b1;
            end else begin
              overrun_d = 1'b1;
              ack_d     = 1'b0;
            end
          end else begin
            state_d = DATA;
          end
        end
        DATA_ACK: begin
          if (fall_v_s) begin
            cnt_clear_s = 1'b1;
            if (ack_q) begin
              state_d = DATA;
            end else begin
              state_d = IGNORE;
            end
          end else begin
            state_d = DATA_ACK;
          end
        end
        IGNORE: begin
          state_d = IGNORE;
        end
        default: begin
          state_d     = IDLE;
          cnt_clear_s = 1'b1;
        end
      endcase
    end
  end

  // Registered outputs derived from the state being entered.
  always_comb begin
    sda_drive_d  = 1'b0;
    addr_match_d = addr_match_q;
    busy_d       = (state_d != IDLE);
    case (state_d)
      ADDR_ACK: sda_drive_d = 1'b1;
      DATA_ACK: sda_drive_d = ack_d;
      default:  sda_drive_d = 1'b0;
    endcase
    if (stop_found || start_found) begin
      addr_match_d = 1'b0;
    end else if (state_d == ADDR_ACK) begin
      addr_match_d = 1'b1;
    end else begin
      addr_match_d = addr_match_q;
    end
  end

  assign sda_drive  = sda_drive_q;
  assign rx_data    = rx_data_q;
  assign rx_full    = rx_full_q;
  assign overrun    = overrun_q;
  assign addr_match = addr_match_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Self-checking bench for i2c_slave_ctrl: directed scenarios followed by
// randomized write transactions checked against a transaction-level model.
module tb_i2c_slave_ctrl;

  localparam logic [6:0] OWN = 7'h2A;
`ifdef I2C_SLAVE_GENCALL_EN
  localparam logic GC = 1'b1;
`else
  localparam logic GC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl_rise = 1'b0, scl_fall = 1'b0;
  logic       start_found = 1'b0, stop_found = 1'b0;
  logic       sda_in = 1'b1, rx_read = 1'b0;
  logic       sda_drive, rx_full, overrun, addr_match, busy;
  logic [7:0] rx_data;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: holding register contents and whether the slave is
  // still listening in the current transaction.
  logic [7:0] m_rx_data;
  logic       m_full, m_ovr, m_listen;

  i2c_slave_ctrl #(.SLAVE_ADDR(OWN)) dut (
    .clk         (clk),
    .rst         (rst),
    .scl_rise    (scl_rise),
    .scl_fall    (scl_fall),
    .start_found (start_found),
    .stop_found  (stop_found),
    .sda_in      (sda_in),
    .rx_read     (rx_read),
    .sda_drive   (sda_drive),
    .rx_data     (rx_data),
    .rx_full     (rx_full),
    .overrun     (overrun),
    .addr_match  (addr_match),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // One-cycle pulse on the selected inputs, driven and released on negedges.
  task automatic pulse(input logic r, input logic f, input logic s, input logic p, input logic rd);
    @(negedge clk);
    scl_rise = r; scl_fall = f; start_found = s; stop_found = p; rx_read = rd;
    @(negedge clk);
    scl_rise = 1'b0; scl_fall = 1'b0; start_found = 1'b0; stop_found = 1'b0; rx_read = 1'b0;
  endtask

  function automatic logic addr_ok(input logic [7:0] b);
    return (b == {OWN, 1'b0}) || (GC && (b == 8'h00));
  endfunction

  task automatic send_start();
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);  // SCL falls after START
  endtask

  task automatic send_stop();
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Clock out nbits MSB-first; a rise+fall glitch with the wrong level is
  // inserted before bit glitch_at.
  task automatic send_bits(input logic [7:0] b, input int nbits, input int glitch_at);
    for (int i = 0; i < nbits; i++) begin
      if (i == glitch_at) begin
        sda_in = ~b[7-i];
        pulse(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      sda_in = b[7-i];
      pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    sda_in = 1'b1;
  endtask

  // Ninth clock: return the SDA pull seen while SCL is high.
  task automatic ack_clock(output logic drv);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drv = sda_drive;
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_sda"},   sda_drive,  1'b0);
    check_eq({tag, "_data"},  rx_data,    8'h00);
    check_eq({tag, "_full"},  rx_full,    1'b0);
    check_eq({tag, "_ovr"},   overrun,    1'b0);
    check_eq({tag, "_match"}, addr_match, 1'b0);
    check_eq({tag, "_busy"},  busy,       1'b0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_rx_data = 8'h00; m_full = 1'b0; m_ovr = 1'b0; m_listen = 1'b0;
    check_reset_outs(tag);
  endtask

  // Model one data byte: store if free, else mark overrun and stop listening.
  task automatic model_byte(input logic [7:0] b, output logic exp_ack);
    if (!m_listen) begin
      exp_ack = 1'b0;
    end else if (!m_full) begin
      m_rx_data = b; m_full = 1'b1; exp_ack = 1'b1;
    end else begin
      m_ovr = 1'b1; m_listen = 1'b0; exp_ack = 1'b0;
    end
  endtask

  task automatic random_txn(input int idx);
    logic [7:0] a, d;
    logic       drv, exp_ack;
    int         nb;
    case ($urandom_range(0, 4))
      0, 1:    a = {OWN, 1'b0};
      2:       a = {OWN, 1'b1};
      3:       a = 8'h00;
      default: a = 8'($urandom);
    endcase
    send_start();
    send_bits(a, 8, $urandom_range(0, 15));
    m_listen = addr_ok(a);
    ack_clock(drv);
    check_eq($sformatf("r%0d_addr_ack", idx), drv, m_listen);
    check_eq($sformatf("r%0d_match", idx), addr_match, m_listen);
    nb = $urandom_range(0, 3);
    for (int k = 0; k < nb; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        m_full = 1'b0;
        check_eq($sformatf("r%0d_pop", idx), rx_full, 1'b0);
      end
      d = 8'($urandom);
      send_bits(d, 8, $urandom_range(0, 15));
      model_byte(d, exp_ack);
      ack_clock(drv);
      check_eq($sformatf("r%0d_b%0d_ack", idx, k), drv, exp_ack);
    end
    send_stop();
    m_listen = 1'b0;
    check_eq($sformatf("r%0d_busy", idx),  busy,       1'b0);
    check_eq($sformatf("r%0d_sda", idx),   sda_drive,  1'b0);
    check_eq($sformatf("r%0d_match0", idx), addr_match, 1'b0);
    check_eq($sformatf("r%0d_data", idx),  rx_data,    m_rx_data);
    check_eq($sformatf("r%0d_full", idx),  rx_full,    m_full);
    check_eq($sformatf("r%0d_ovr", idx),   overrun,    m_ovr);
  endtask

  initial begin
    logic drv;

    // Reset state.
    do_reset("rst0");

    // Matching address, then A5; a same-cycle rise/fall glitch is ignored.
    send_start();
    check_eq("s1_busy", busy, 1'b1);
    send_bits(8'h54, 8, 3);
    ack_clock(drv);
    check_eq("s1_addr_ack", drv, 1'b1);
    check_eq("s1_release", sda_drive, 1'b0);
    check_eq("s1_match", addr_match, 1'b1);
    send_bits(8'hA5, 8, -1);
    ack_clock(drv);
    check_eq("s1_data_ack", drv, 1'b1);
    check_eq("s1_rx_data", rx_data, 8'hA5);
    check_eq("s1_rx_full", rx_full, 1'b1);
    send_stop();
    check_eq("s1_stop_busy", busy, 1'b0);
    check_eq("s1_keep_data", rx_data, 8'hA5);

    // Wrong address: no ACK, ignored until STOP.
    send_start();
    send_bits(8'h56, 8, -1);
    ack_clock(drv);
    check_eq("s2_nack", drv, 1'b0);
    check_eq("s2_busy", busy, 1'b1);
    check_eq("s2_match", addr_match, 1'b0);
    send_bits(8'hFF, 8, -1);
    ack_clock(drv);
    check_eq("s2_ign_ack", drv, 1'b0);
    send_stop();
    check_eq("s2_stop_busy", busy, 1'b0);

    // Two bytes without a pop: second is NACKed and flags overrun.
    do_reset("rst3");
    send_start();
    send_bits(8'h54, 8, -1);
    ack_clock(drv);
    check_eq("s3_addr_ack", drv, 1'b1);
    send_bits(8'h11, 8, -1);
    ack_clock(drv);
    check_eq("s3_b1_ack", drv, 1'b1);
    send_bits(8'h22, 8, -1);
    ack_clock(drv);
    check_eq("s3_b2_nack", drv, 1'b0);
    check_eq("s3_ovr", overrun, 1'b1);
    check_eq("s3_data", rx_data, 8'h11);
    send_bits(8'h33, 8, -1);
    ack_clock(drv);
    check_eq("s3_b3_nack", drv, 1'b0);
    send_stop();
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("s3_pop", rx_full, 1'b0);
    check_eq("s3_ovr_sticky", overrun, 1'b1);

    // Repeated START after 4 address bits restarts the byte.
    do_reset("rst4");
    send_start();
    send_bits(8'h54, 4, -1);
    send_start();
    check_eq("s4_rs_match", addr_match, 1'b0);
    send_bits(8'h54, 8, -1);
    ack_clock(drv);
    check_eq("s4_addr_ack", drv, 1'b1);
    send_stop();

    // Reset in the middle of the address ACK.
    send_start();
    send_bits(8'h54, 8, -1);
    check_eq("s5_in_ack", sda_drive, 1'b1);
    @(negedge clk);
    rst = 1'b1; scl_fall = 1'b1;
    @(negedge clk);
    rst = 1'b0; scl_fall = 1'b0;
    check_reset_outs("s5");

    // General-call address byte.
    do_reset("rst6");
    send_start();
    send_bits(8'h00, 8, -1);
    ack_clock(drv);
    check_eq("s6_gencall", drv, GC);
    send_stop();

    // Randomized transactions against the model.
    do_reset("rst7");
    for (int t = 0; t < 40; t++) begin
      if (t % 10 == 9) begin
        do_reset($sformatf("rrst%0d", t));
      end
      random_txn(t);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
